// File: rtl/mul_err_monitor.sv
// mul_err_monitor: error-statistics collector for a 16x16 approximate
// unsigned multiplier. Each accepted sample (A, B, Z) goes through a three-stage
// pipeline that recomputes A*B and forms |A*B - Z|. An accumulate stage then
// updates the sum of absolute errors, the worst-case error and the count of
// erroneous samples over a run of n_samples samples.
// Optional feature: define MUL_ERR_MONITOR_WORST_OPS_EN to add worst_a/worst_b,
// which hold the operands of the earliest sample that reached the current wce.
module mul_err_monitor #(
    parameter int W     = 16,
    parameter int CNT_W = 17,
    parameter int SUM_W = 2*W + CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [2*W-1:0]   in_z,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] err_sum,
    output logic [2*W-1:0]   wce,
`ifdef MUL_ERR_MONITOR_WORST_OPS_EN
    output logic [W-1:0]     worst_a,
    output logic [W-1:0]     worst_b,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q;
    logic               busy_q, done_q;
    logic [CNT_W-1:0]   cnt_q, n_q;
    logic [CNT_W-1:0]   cnt_inc;

    // pipeline registers
    logic               v1_q, v2_q, v3_q;
    logic [W-1:0]       a1_q, b1_q;
    logic [2*W-1:0]     z1_q, exact2_q, z2_q, diff3_q;
    logic               neq3_q;

    // statistics
    logic [SUM_W-1:0]   err_sum_q;
    logic [2*W-1:0]     wce_q;
    logic [CNT_W-1:0]   err_cnt_q;

    logic accept;
    logic clear_stats;

    // in_ready is derived only from registered state so it never depends on in_valid
    assign in_ready    = (state_q == RUN) && (cnt_q < n_q);
    assign accept      = in_valid & in_ready;
    assign clear_stats = (state_q == IDLE) & start;
    assign cnt_inc     = cnt_q + CNT_W'(1);

    assign busy    = busy_q;
    assign done    = done_q;
    assign err_sum = err_sum_q;
    assign wce     = wce_q;
    assign err_cnt = err_cnt_q;

    // run-control FSM with registered busy/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            n_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        n_q    <= n_samples;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (n_samples != '0) begin
                            state_q <= RUN;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == n_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // the accumulate update for a set v3 happens on this same edge
                    if (!(v1_q | v2_q | v3_q)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // three-stage datapath: capture, exact multiply, absolute difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            a1_q     <= '0;
            b1_q     <= '0;
            z1_q     <= '0;
            exact2_q <= '0;
            z2_q     <= '0;
            diff3_q  <= '0;
            neq3_q   <= 1'b0;
        end else begin
            v1_q <= accept;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (accept) begin
                a1_q <= in_a;
                b1_q <= in_b;
                z1_q <= in_z;
            end
            exact2_q <= {{W{1'b0}}, a1_q} * {{W{1'b0}}, b1_q};
            z2_q     <= z1_q;
            diff3_q  <= (exact2_q >= z2_q) ? (exact2_q - z2_q) : (z2_q - exact2_q);
            neq3_q   <= (exact2_q != z2_q);
        end
    end

    // accumulate stage; a start in IDLE clears the previous run's figures
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum_q <= '0;
            wce_q     <= '0;
            err_cnt_q <= '0;
        end else if (clear_stats) begin
            err_sum_q <= '0;
            wce_q     <= '0;
            err_cnt_q <= '0;
        end else if (v3_q) begin
            err_sum_q <= err_sum_q + SUM_W'(diff3_q);
            err_cnt_q <= err_cnt_q + CNT_W'(neq3_q);
            if (diff3_q > wce_q) begin
                wce_q <= diff3_q;
            end
        end
    end

`ifdef MUL_ERR_MONITOR_WORST_OPS_EN
    logic [W-1:0] a2_q, b2_q, a3_q, b3_q;
    logic [W-1:0] worst_a_q, worst_b_q;

    assign worst_a = worst_a_q;
    assign worst_b = worst_b_q;

    // operands ride alongside the datapath; strict compare keeps the earliest tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a2_q      <= '0;
            b2_q      <= '0;
            a3_q      <= '0;
            b3_q      <= '0;
            worst_a_q <= '0;
            worst_b_q <= '0;
        end else begin
            a2_q <= a1_q;
            b2_q <= b1_q;
            a3_q <= a2_q;
            b3_q <= b2_q;
            if (clear_stats) begin
                worst_a_q <= '0;
                worst_b_q <= '0;
            end else if (v3_q && (diff3_q > wce_q)) begin
                worst_a_q <= a3_q;
                worst_b_q <= b3_q;
            end
        end
    end
`endif

endmodule
